pcileech_tx_sched: RTL and testbench
====================================

Name: pcileech_tx_sched

Overview:
- Sequences the host-bound (FPGA-to-FT601) output path.
- Accepts 256-bit words from the FIFO controller and serialises them into the 32-bit output FIFO that feeds the FT601 controller, one dword per cycle, honouring almost-full backpressure.
- Owns the FTDI transfer-termination workaround: inserts exactly one MAGIC dword at the start of each new output stream, so host transfers are never an exact multiple of 1024 bytes.

Parameters:
- MAGIC, 32'h66665555, workaround dword written at stream start.
- HOLDOFF, 4, consecutive idle-and-empty cycles required before MAGIC may be written (range 1..255).

Ports:
- clk  in  1  system clock (100 MHz); the block uses this single clock.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  256  word from FIFO controller; dword k = in_data[32k+31:32k].
- in_valid  in  1  in_data valid.
- in_ready  out  1  combinational; a transfer occurs when in_valid & in_ready.
- out_data  out  32  dword to output FIFO din.
- out_wr_en  out  1  output FIFO write strobe.
- out_almost_full  in  1  output FIFO almost_full.
- out_empty  in  1  output FIFO empty.
- ft601_txe_n  in  1  FT601 TXE_N pad level (1 = host not accepting).
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values: state=IDLE, idx=0, out_wr_en=0, out_data=0, magic_done=0, idle_cnt=0. in_ready=0 while rst=1.
- Reset mid-word discards the held word and its remaining dwords; no further writes occur after the reset cycle.
- out_data and out_wr_en are registered. A write decided in cycle N appears in cycle N+1.
- States:
  - IDLE:
    - in_ready=1.
    - If in_valid: latch in_data into hold register, set idx=0, go to SHIFT. This takes priority over MAGIC.
    - Else if magic_done=0 & idle_cnt>=HOLDOFF: register MAGIC with out_wr_en=1 for one cycle, set magic_done=1, stay in IDLE.
  - SHIFT:
    - Each cycle with out_almost_full=0: write hold dword[idx], idx<=idx+1, magic_done<=0.
    - Cycle with out_almost_full=1: no write; idx and hold register unchanged.
    - On the idx=7 write: in_ready=1. If in_valid, latch the next word and set idx=0 (back-to-back, no bubble); else go to IDLE.
    - in_ready=0 in SHIFT at all other times.
- idle_cnt (8-bit, saturating):
  - Increments while state=IDLE & out_empty=1 & ft601_txe_n=1 & in_valid=0.
  - Cleared on any other cycle and on every write.
- Dword order within a word: 0 first, 7 last. A 256-bit word always produces exactly 8 contiguous writes unless stalled.
- MAGIC appears at most once between consecutive data streams. It is never written between dwords of a word, and never while state=SHIFT.
- Throughput: 8 dwords per 8 cycles with no backpressure. Latency from in_valid&in_ready to first out_wr_en is 1 cycle.

Optional Feature:
- Macro: PCILEECH_TX_SCHED_STATS_EN.
- When defined, adds three extra output ports:
  - stat_words (32-bit): count of accepted 256-bit words.
  - stat_magic (16-bit): count of MAGIC writes.
  - stat_stall (32-bit): count of SHIFT cycles with out_almost_full=1.
- All counters are wrapping, cleared by rst, and registered.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then out_empty=1, ft601_txe_n=1, in_valid=0 for 10 cycles -> exactly one out_wr_en with out_data=32'h66665555, asserted on the cycle after idle_cnt reaches 4; none after.
- Send one word with dword k = 32'h1000_0000+k, out_almost_full=0 -> out_wr_en high for 8 consecutive cycles starting 1 cycle after acceptance, data 10000000..10000007; busy drops after the last write.
- Two words back-to-back with in_valid held high -> 16 consecutive writes with no gap; in_ready high only on the acceptance cycles.
- Raise out_almost_full for 3 cycles after dword 2 is written -> writes pause for 3 cycles, resume with dword 3; no dword lost or repeated.
- Empty-and-idle window, then in_valid asserted on the same cycle MAGIC becomes eligible -> data wins and no MAGIC is written. After the stream ends, MAGIC is written once after 4 idle-empty cycles.
- Assert rst while idx=4 -> no out_wr_en from the next cycle onward, in_ready=0 during reset, then IDLE with magic_done=0 once rst is released.

Source files
------------

// File: rtl/pcileech_tx_sched.sv
// ----------------------------------------------------------------------------
// pcileech_tx_sched
//
// Host-bound output scheduler. Takes 256-bit words from the FIFO controller
// and serialises them, dword 0 first, into the 32-bit output FIFO feeding the
// FT601 controller, one dword per cycle, stalling on almost-full. Also inserts
// a single MAGIC dword at the start of each new output stream so that host
// transfers never end on an exact multiple of 1024 bytes.
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   in_data          256-bit word, dword k = in_data[32k+31:32k]
//   in_valid         in_data valid
//   in_ready         combinational accept (transfer on in_valid & in_ready)
//   out_data         registered dword to output FIFO din
//   out_wr_en        registered output FIFO write strobe
//   out_almost_full  output FIFO almost_full
//   out_empty        output FIFO empty
//   ft601_txe_n      FT601 TXE_N pad level (1 = host not accepting)
//   busy             high while serialising a word
//
// Optional build macro PCILEECH_TX_SCHED_STATS_EN adds wrapping counters:
//   stat_words       accepted 256-bit words
//   stat_magic       MAGIC dwords written
//   stat_stall       serialising cycles lost to almost_full
// ----------------------------------------------------------------------------
module pcileech_tx_sched #(
    parameter logic [31:0] MAGIC   = 32'h66665555,
    parameter int unsigned HOLDOFF = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_wr_en,
    input  logic         out_almost_full,
    input  logic         out_empty,
    input  logic         ft601_txe_n,
    output logic         busy
`ifdef PCILEECH_TX_SCHED_STATS_EN
    ,
    output logic [31:0]  stat_words,
    output logic [15:0]  stat_magic,
    output logic [31:0]  stat_stall
`endif
);

    localparam logic [7:0] HOLDOFF_C = 8'(HOLDOFF);

    typedef enum logic [0:0] {StIdle, StShift} state_t;

    state_t           state;
    logic [7:0][31:0] hold;
    logic [2:0]       idx;
    logic             magic_done;
    logic [7:0]       idle_cnt;

    // The last dword of a word frees the hold register in the same cycle,
    // which is what makes back-to-back words gapless.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state == StIdle) begin
                in_ready = 1'b1;
            end else if (idx == 3'd7 && !out_almost_full) begin
                in_ready = 1'b1;
            end
        end
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            hold       <= '0;
            idx        <= 3'd0;
            out_data   <= 32'd0;
            out_wr_en  <= 1'b0;
            magic_done <= 1'b0;
            idle_cnt   <= 8'd0;
        end else begin
            out_wr_en <= 1'b0;
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        // Data takes priority over a pending MAGIC.
                        hold     <= in_data;
                        idx      <= 3'd0;
                        state    <= StShift;
                        idle_cnt <= 8'd0;
                    end else if (!magic_done && idle_cnt >= HOLDOFF_C) begin
                        out_data   <= MAGIC;
                        out_wr_en  <= 1'b1;
                        magic_done <= 1'b1;
                        idle_cnt   <= 8'd0;
                    end else if (out_empty && ft601_txe_n) begin
                        if (idle_cnt != 8'hff) begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                    end else begin
                        idle_cnt <= 8'd0;
                    end
                end
                StShift: begin
                    idle_cnt <= 8'd0;
                    if (!out_almost_full) begin
                        out_data   <= hold[idx];
                        out_wr_en  <= 1'b1;
                        magic_done <= 1'b0;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            if (in_valid) begin
                                hold <= in_data;
                                idx  <= 3'd0;
                            end else begin
                                state <= StIdle;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef PCILEECH_TX_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words <= 32'd0;
            stat_magic <= 16'd0;
            stat_stall <= 32'd0;
        end else begin
            if (in_valid && in_ready) begin
                stat_words <= stat_words + 32'd1;
            end
            if (state == StIdle && !in_valid && !magic_done && idle_cnt >= HOLDOFF_C) begin
                stat_magic <= stat_magic + 16'd1;
            end
            if (state == StShift && out_almost_full) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcileech_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_pcileech_tx_sched
//
// Directed self-checking bench for pcileech_tx_sched: MAGIC insertion after
// idle hold-off, single and back-to-back word serialisation, almost-full
// stall, data-over-MAGIC priority and reset mid-word. Every write is logged
// with its cycle number on the falling edge and checked against hand-computed
// expectations.
// ----------------------------------------------------------------------------
module tb_pcileech_tx_sched;

    localparam logic [31:0] MAGIC = 32'h66665555;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_wr_en;
    logic         out_almost_full;
    logic         out_empty;
    logic         ft601_txe_n;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    pcileech_tx_sched dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_wr_en       (out_wr_en),
        .out_almost_full (out_almost_full),
        .out_empty       (out_empty),
        .ft601_txe_n     (ft601_txe_n),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_wr_en === 1'b1) begin
            wq_data.push_back(out_data);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mkword(input logic [31:0] base);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = base + k;
        return w;
    endfunction

    task automatic clear_log();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    // Presents one word in IDLE and returns just after the accepting edge.
    task automatic send_word(input logic [255:0] w, input string tag);
        in_data  = w;
        in_valid = 1'b1;
        #1;
        check(tag, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_dword(input logic [31:0] d, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (out_wr_en === 1'b1 && out_data === d) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic check_word(input logic [31:0] base, input int first, input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_d%0d", tag, k), wq_data[first+k], base + k);
        end
    endtask

    initial begin
        int rel;
        int acc;
        int nacc;
        int nvalid;
        bit r;

        rst             = 1'b1;
        in_data         = '0;
        in_valid        = 1'b0;
        out_almost_full = 1'b0;
        out_empty       = 1'b1;
        ft601_txe_n     = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", out_data, 32'd0);

        // MAGIC after hold-off: 4 counting edges, written on the 5th
        clear_log();
        rst = 1'b0;
        rel = cyc;
        repeat (20) step();
        check("magic_count", wq_data.size(), 32'd1);
        if (wq_data.size() >= 1) begin
            check("magic_data", wq_data[0], MAGIC);
            check("magic_cyc", wq_cyc[0], rel + 5);
        end

        // Single word
        out_empty = 1'b0;
        clear_log();
        send_word(mkword(32'h1000_0000), "w1_ready");
        acc = cyc;
        repeat (10) step();
        check("w1_count", wq_data.size(), 32'd8);
        if (wq_data.size() == 8) begin
            check_word(32'h1000_0000, 0, "w1");
            for (int k = 0; k < 8; k++) check($sformatf("w1_cyc%0d", k), wq_cyc[k], acc + 1 + k);
        end
        check("w1_busy_end", {31'd0, busy}, 32'd0);

        // Two words back-to-back
        clear_log();
        in_data  = mkword(32'hA000_0000);
        in_valid = 1'b1;
        nacc     = 0;
        nvalid   = 0;
        for (int i = 0; i < 30 && in_valid; i++) begin
            #0;
            r = in_ready;
            nvalid++;
            step();
            if (r) begin
                nacc++;
                if (nacc == 1) in_data = mkword(32'hB000_0000);
                else in_valid = 1'b0;
            end
        end
        repeat (10) step();
        check("b2b_accepts", nacc, 32'd2);
        check("b2b_valid_cycles", nvalid, 32'd9);
        check("b2b_count", wq_data.size(), 32'd16);
        if (wq_data.size() == 16) begin
            check_word(32'hA000_0000, 0, "b2b_a");
            check_word(32'hB000_0000, 8, "b2b_b");
            for (int i = 1; i < 16; i++) check($sformatf("b2b_gap%0d", i), wq_cyc[i] - wq_cyc[i-1], 32'd1);
        end

        // Almost-full stall after dword 2
        clear_log();
        send_word(mkword(32'h2000_0000), "st_ready");
        wait_dword(32'h2000_0002, "st_see_d2");
        out_almost_full = 1'b1;
        repeat (3) step();
        check("st_busy", {31'd0, busy}, 32'd1);
        out_almost_full = 1'b0;
        repeat (12) step();
        check("st_count", wq_data.size(), 32'd8);
        if (wq_data.size() == 8) begin
            check_word(32'h2000_0000, 0, "st");
            for (int i = 1; i < 8; i++) begin
                check($sformatf("st_gap%0d", i), wq_cyc[i] - wq_cyc[i-1], (i == 3) ? 32'd4 : 32'd1);
            end
        end

        // Data wins over MAGIC on the eligible cycle; MAGIC follows the stream
        clear_log();
        out_empty = 1'b1;
        repeat (4) step();
        check("pri_no_early", wq_data.size(), 32'd0);
        send_word(mkword(32'hC000_0000), "pri_ready");
        acc = cyc;
        repeat (25) step();
        check("pri_count", wq_data.size(), 32'd9);
        if (wq_data.size() == 9) begin
            check_word(32'hC000_0000, 0, "pri");
            check("pri_first_cyc", wq_cyc[0], acc + 1);
            check("pri_magic", wq_data[8], MAGIC);
            check("pri_magic_cyc", wq_cyc[8] - wq_cyc[7], 32'd5);
        end

        // Reset while idx=4
        out_empty = 1'b0;
        clear_log();
        send_word(mkword(32'h3000_0000), "rs_ready");
        wait_dword(32'h3000_0003, "rs_see_d3");
        rst = 1'b1;
        #1;
        check("rs_in_ready0", {31'd0, in_ready}, 32'd0);
        step();
        check("rs_wr_en0", {31'd0, out_wr_en}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        step();
        check("rs_wr_en1", {31'd0, out_wr_en}, 32'd0);
        check("rs_in_ready1", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        repeat (3) step();
        check("rs_idle_ready", {31'd0, in_ready}, 32'd1);
        check("rs_count", wq_data.size(), 32'd4);
        if (wq_data.size() == 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("rs_d%0d", k), wq_data[k], 32'h3000_0000 + k);
        end
        clear_log();
        out_empty = 1'b1;
        rel = cyc;
        repeat (12) step();
        check("rs_magic_count", wq_data.size(), 32'd1);
        if (wq_data.size() == 1) begin
            check("rs_magic_data", wq_data[0], MAGIC);
            check("rs_magic_cyc", wq_cyc[0], rel + 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
